// File: rtl/mem_req_arbiter_pkg.sv
// Shared encodings and helpers for the memory request arbiter slice.
// The optional fetch aging feature is enabled by defining MEM_ARB_AGING_EN.
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arbState_t;

  typedef enum logic [1:0] {
    OWN_FETCH = 2'd0,
    OWN_LOAD  = 2'd1,
    OWN_STORE = 2'd2
  } arbOwner_t;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  localparam int unsigned IO_BASE_DEFAULT = 32'h0003_0000;

  // Any size code the engine does not understand is issued as a full word.
  function automatic logic [2:0] normSize(input logic [2:0] size);
    case (size)
      SZ_B, SZ_H: return size;
      default:    return SZ_W;
    endcase
  endfunction

  function automatic logic [31:0] sizeMask(input logic [2:0] size);
    case (size)
      SZ_B:    return 32'h0000_00FF;
      SZ_H:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_age_ctr.sv
// Saturating wait counter that forces the next idle grant to fetch once it reaches LIMIT.
// Only instantiated when MEM_ARB_AGING_EN is defined.
module mem_arb_age_ctr #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rdy,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_forceFetch
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_rdy) begin
      if (i_clr) begin
        r_count <= '0;
      end else if (i_inc && (r_count != CntW'(LIMIT))) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_forceFetch = (r_count == CntW'(LIMIT));

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the byte-serial memory engine between i-cache fetch and LSB loads/stores.
// Define MEM_ARB_AGING_EN to add fetch anti-starvation aging (mem_arb_age_ctr).
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned IO_BASE      = IO_BASE_DEFAULT,
  parameter int unsigned IO_SPAN      = 8,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              io_buffer_full,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [31:0]       fetch_data,
  input  logic              lsb_req,
  input  logic              lsb_we,
  input  logic [2:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_ack,
  output logic [31:0]       lsb_rdata,
  output logic              mc_req,
  output logic              mc_we,
  output logic [2:0]        mc_size,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [31:0]       mc_wdata,
  input  logic              mc_done,
  input  logic [31:0]       mc_rdata
);

  localparam logic [ADDR_W-1:0] IoLo = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] IoHi = ADDR_W'(IO_BASE + IO_SPAN);

  arbState_t r_state;
  arbOwner_t r_owner;
  logic      r_cancel;

  logic w_idle;
  logic w_lsbInIo;
  logic w_storeOk;
  logic w_loadOk;
  logic w_fetchOk;
  logic w_forceFetch;
  logic w_grantFetch;
  logic w_grantStore;
  logic w_grantLoad;
  logic w_flushFetch;

  assign w_idle    = (r_state == ARB_IDLE);
  assign w_lsbInIo = (lsb_addr >= IoLo) && (lsb_addr < IoHi);
  // A held IO store simply drops out of the race, letting load/fetch proceed.
  assign w_storeOk = lsb_req && lsb_we && (!w_lsbInIo || !io_buffer_full);
  assign w_loadOk  = lsb_req && !lsb_we;
  assign w_fetchOk = fetch_req && !flush;

  assign w_grantFetch = w_idle && w_fetchOk && (w_forceFetch || !(w_storeOk || w_loadOk));
  assign w_grantStore = w_idle && w_storeOk && !w_grantFetch;
  assign w_grantLoad  = w_idle && w_loadOk && !w_storeOk && !w_grantFetch;
  assign w_flushFetch = flush && (r_owner == OWN_FETCH);

`ifdef MEM_ARB_AGING_EN
  logic w_ageInc;
  logic w_ageClr;

  assign w_ageInc = w_idle && fetch_req && (w_grantStore || w_grantLoad);
  assign w_ageClr = w_grantFetch || flush;

  mem_arb_age_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_ageCtr (
    .clk         (clk),
    .rst         (rst),
    .i_rdy       (rdy),
    .i_inc       (w_ageInc),
    .i_clr       (w_ageClr),
    .o_forceFetch(w_forceFetch)
  );
`else
  assign w_forceFetch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_owner    <= OWN_FETCH;
      r_cancel   <= 1'b0;
      mc_req     <= 1'b0;
      mc_we      <= 1'b0;
      mc_size    <= '0;
      mc_addr    <= '0;
      mc_wdata   <= '0;
      fetch_ack  <= 1'b0;
      fetch_data <= '0;
      lsb_ack    <= 1'b0;
      lsb_rdata  <= '0;
    end else if (rdy) begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grantFetch || w_grantStore || w_grantLoad) begin
            r_state  <= ARB_ISSUE;
            r_cancel <= 1'b0;
            mc_req   <= 1'b1;
            if (w_grantFetch) begin
              r_owner  <= OWN_FETCH;
              mc_we    <= 1'b0;
              mc_size  <= SZ_W;
              mc_addr  <= fetch_addr;
              mc_wdata <= '0;
            end else begin
              r_owner  <= w_grantStore ? OWN_STORE : OWN_LOAD;
              mc_we    <= w_grantStore;
              mc_size  <= normSize(lsb_size);
              mc_addr  <= lsb_addr;
              mc_wdata <= w_grantStore ? lsb_wdata : 32'h0;
            end
          end
        end
        ARB_ISSUE: begin
          mc_req  <= 1'b0;
          r_state <= ARB_WAIT;
          if (w_flushFetch) r_cancel <= 1'b1;
        end
        ARB_WAIT: begin
          if (w_flushFetch) r_cancel <= 1'b1;
          // A flush landing on the completion cycle still cancels the fetch.
          if (mc_done) begin
            r_state <= ARB_RESP;
            case (r_owner)
              OWN_FETCH: begin
                if (!(r_cancel || flush)) begin
                  fetch_data <= mc_rdata;
                  fetch_ack  <= 1'b1;
                end
              end
              OWN_LOAD: begin
                lsb_rdata <= mc_rdata & sizeMask(mc_size);
                lsb_ack   <= 1'b1;
              end
              default: lsb_ack <= 1'b1;
            endcase
          end
        end
        default: begin
          fetch_ack <= 1'b0;
          lsb_ack   <= 1'b0;
          r_state   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter; the engine is driven by hand.
// Aging expectations follow MEM_ARB_AGING_EN when the bench is built with it.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

`ifdef MEM_ARB_AGING_EN
  localparam bit AgingOn = 1'b1;
`else
  localparam bit AgingOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, flush, io_buffer_full;
  logic        fetch_req, fetch_ack;
  logic [31:0] fetch_addr, fetch_data;
  logic        lsb_req, lsb_we, lsb_ack;
  logic [2:0]  lsb_size;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic        mc_req, mc_we, mc_done;
  logic [2:0]  mc_size;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .ADDR_W      (32),
    .IO_BASE     (32'h0003_0000),
    .IO_SPAN     (8),
    .STARVE_LIMIT(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .flush         (flush),
    .io_buffer_full(io_buffer_full),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ack     (fetch_ack),
    .fetch_data    (fetch_data),
    .lsb_req       (lsb_req),
    .lsb_we        (lsb_we),
    .lsb_size      (lsb_size),
    .lsb_addr      (lsb_addr),
    .lsb_wdata     (lsb_wdata),
    .lsb_ack       (lsb_ack),
    .lsb_rdata     (lsb_rdata),
    .mc_req        (mc_req),
    .mc_we         (mc_we),
    .mc_size       (mc_size),
    .mc_addr       (mc_addr),
    .mc_wdata      (mc_wdata),
    .mc_done       (mc_done),
    .mc_rdata      (mc_rdata)
  );

  // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called in the ISSUE cycle; waits extra cycles in WAIT, then completes; returns in RESP.
  task automatic serve(input logic [31:0] data, input int extraWait);
    applyStimulus();
    repeat (extraWait) applyStimulus();
    mc_done  = 1'b1;
    mc_rdata = data;
    applyStimulus();
    mc_done  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    lsb_req = 1'b0; lsb_we = 1'b0; lsb_size = 3'd4; lsb_addr = '0; lsb_wdata = '0;
    mc_done = 1'b0; mc_rdata = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("reset mc_req", {31'b0, mc_req}, 32'h0);
    checkOutput("reset mc_addr", mc_addr, 32'h0);
    checkOutput("reset acks", {30'b0, fetch_ack, lsb_ack}, 32'h0);
    checkOutput("reset fetch_data", fetch_data, 32'h0);
    rst = 1'b0;

    $display("[TB] lone fetch");
    fetch_req = 1'b1; fetch_addr = 32'h100;
    applyStimulus();
    checkOutput("t1 mc_req", {31'b0, mc_req}, 32'h1);
    checkOutput("t1 mc_addr", mc_addr, 32'h100);
    checkOutput("t1 mc_we", {31'b0, mc_we}, 32'h0);
    applyStimulus();
    checkOutput("t1 mc_req one cycle", {31'b0, mc_req}, 32'h0);
    applyStimulus();
    applyStimulus();
    checkOutput("t1 mc_addr held", mc_addr, 32'h100);
    checkOutput("t1 no early ack", {31'b0, fetch_ack}, 32'h0);
    mc_done = 1'b1; mc_rdata = 32'h1234_5678;
    applyStimulus();
    mc_done = 1'b0; fetch_req = 1'b0;
    checkOutput("t1 fetch_ack", {31'b0, fetch_ack}, 32'h1);
    checkOutput("t1 fetch_data", fetch_data, 32'h1234_5678);
    applyStimulus();
    checkOutput("t1 ack pulse", {31'b0, fetch_ack}, 32'h0);

    $display("[TB] store beats fetch");
    fetch_req = 1'b1; fetch_addr = 32'h104;
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 3'd4; lsb_addr = 32'h200; lsb_wdata = 32'hDEAD_BEEF;
    applyStimulus();
    checkOutput("t2 store mc_we", {31'b0, mc_we}, 32'h1);
    checkOutput("t2 store mc_addr", mc_addr, 32'h200);
    checkOutput("t2 store mc_wdata", mc_wdata, 32'hDEAD_BEEF);
    checkOutput("t2 store mc_size", {29'b0, mc_size}, 32'h4);
    serve(32'h0, 0);
    checkOutput("t2 lsb_ack", {31'b0, lsb_ack}, 32'h1);
    checkOutput("t2 no fetch_ack", {31'b0, fetch_ack}, 32'h0);
    lsb_req = 1'b0;
    applyStimulus();
    checkOutput("t2 idle bubble", {31'b0, mc_req}, 32'h0);
    applyStimulus();
    checkOutput("t2 fetch issued", {31'b0, mc_req}, 32'h1);
    checkOutput("t2 fetch mc_addr", mc_addr, 32'h104);
    serve(32'hCAFE_F00D, 0);
    checkOutput("t2 fetch_data", fetch_data, 32'hCAFE_F00D);
    fetch_req = 1'b0;
    applyStimulus();

    $display("[TB] held IO store");
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 3'd1; lsb_addr = 32'h3_0000; lsb_wdata = 32'hA5;
    io_buffer_full = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h108;
    applyStimulus();
    checkOutput("t3 fetch wins", mc_addr, 32'h108);
    serve(32'h1111_1111, 1);
    checkOutput("t3 fetch_ack", {31'b0, fetch_ack}, 32'h1);
    fetch_req = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("t3 store held", {31'b0, mc_req}, 32'h0);
    io_buffer_full = 1'b0;
    applyStimulus();
    checkOutput("t3 store issued", {31'b0, mc_req}, 32'h1);
    checkOutput("t3 store addr", mc_addr, 32'h3_0000);
    checkOutput("t3 store size", {29'b0, mc_size}, 32'h1);
    serve(32'h0, 0);
    checkOutput("t3 lsb_ack", {31'b0, lsb_ack}, 32'h1);
    lsb_req = 1'b0;
    applyStimulus();

    $display("[TB] flushed fetch");
    fetch_req = 1'b1; fetch_addr = 32'h10C;
    applyStimulus();
    applyStimulus();
    flush = 1'b1; fetch_req = 1'b0;
    applyStimulus();
    flush = 1'b0;
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 3'd2; lsb_addr = 32'h400;
    mc_done = 1'b1; mc_rdata = 32'h9999_9999;
    applyStimulus();
    mc_done = 1'b0;
    checkOutput("t4 fetch_ack suppressed", {31'b0, fetch_ack}, 32'h0);
    checkOutput("t4 fetch_data kept", fetch_data, 32'h1111_1111);
    checkOutput("t4 no lsb_ack", {31'b0, lsb_ack}, 32'h0);
    applyStimulus();
    applyStimulus();
    checkOutput("t4 load issued", {31'b0, mc_req}, 32'h1);
    checkOutput("t4 load addr", mc_addr, 32'h400);
    serve(32'hABCD_1234, 0);
    checkOutput("t4 lsb_ack", {31'b0, lsb_ack}, 32'h1);
    checkOutput("t4 half zero-extended", lsb_rdata, 32'h0000_1234);
    lsb_req = 1'b0;
    applyStimulus();

    $display("[TB] continuous loads vs fetch");
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 3'd3; lsb_addr = 32'h500;
    fetch_req = 1'b1; fetch_addr = 32'h600;
    for (int g = 1; g <= 9; g++) begin
      logic expFetch;
      expFetch = AgingOn && (g == 9);
      applyStimulus();
      checkOutput($sformatf("t5 grant %0d addr", g), mc_addr, expFetch ? 32'h600 : 32'h500);
      checkOutput($sformatf("t5 grant %0d size", g), {29'b0, mc_size}, 32'h4);
      serve(32'hF000_0000 + 32'(g), 0);
      checkOutput($sformatf("t5 grant %0d lsb_ack", g), {31'b0, lsb_ack}, expFetch ? 32'h0 : 32'h1);
      if (!expFetch) checkOutput($sformatf("t5 grant %0d rdata", g), lsb_rdata, 32'hF000_0000 + 32'(g));
      if (g == 9) begin
        lsb_req = 1'b0; fetch_req = 1'b0;
      end
      applyStimulus();
    end

    $display("[TB] reset mid-transaction");
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 3'd4; lsb_addr = 32'h700; lsb_wdata = 32'h5555_5555;
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0; lsb_req = 1'b0;
    checkOutput("t6 mc cleared", {mc_req, mc_we, 27'b0, mc_size} | mc_addr | mc_wdata, 32'h0);
    checkOutput("t6 no ack", {30'b0, fetch_ack, lsb_ack}, 32'h0);
    applyStimulus();
    checkOutput("t6 still no ack", {31'b0, lsb_ack}, 32'h0);
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 3'd1; lsb_addr = 32'h800;
    applyStimulus();
    checkOutput("t6 new issue", {31'b0, mc_req}, 32'h1);
    checkOutput("t6 new addr", mc_addr, 32'h800);
    serve(32'hFFFF_FF80, 0);
    checkOutput("t6 byte zero-extended", lsb_rdata, 32'h0000_0080);
    lsb_req = 1'b0;
    applyStimulus();

    $display("[TB] rdy freeze");
    fetch_req = 1'b1; fetch_addr = 32'h900;
    applyStimulus();
    applyStimulus();
    rdy = 1'b0; mc_done = 1'b1; mc_rdata = 32'h7777_0000;
    applyStimulus();
    checkOutput("t7 frozen no ack", {31'b0, fetch_ack}, 32'h0);
    rdy = 1'b1;
    applyStimulus();
    mc_done = 1'b0; fetch_req = 1'b0;
    checkOutput("t7 ack after rdy", {31'b0, fetch_ack}, 32'h1);
    checkOutput("t7 fetch_data", fetch_data, 32'h7777_0000);
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
